program_mem_responder: RTL and testbench

Memory-side responder for the program-memory read protocol issued by the per-core instruction fetchers. It accepts read requests from NUM_CONSUMERS fetchers and arbitrates them round-robin onto one backing program-memory channel. It relays each returned instruction word back to the granted fetcher with a level ready/valid handshake. It sits between the cores' fetchers and the external program memory.

---
 rtl/program_mem_responder.sv | 115 +++++++++++
 tb/tb_program_mem_responder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_mem_responder.sv
// rtl/program_mem_responder.sv - round-robin program-memory read responder for per-core fetchers
module program_mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data
);

  localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    RELAY    = 2'd2
  } state_t;

  state_t                 state_q;
  logic [PTR_W-1:0]       g_q;
  logic [PTR_W-1:0]       p_q;
  logic                   mem_valid_q;
  logic [ADDR_BITS-1:0]   mem_addr_q;
  logic [NUM_CONSUMERS-1:0] ready_q;
  logic [DATA_BITS-1:0]   data_q [NUM_CONSUMERS];

  logic [ADDR_BITS-1:0]   addr_arr [NUM_CONSUMERS];
  logic                   any_req_d;
  logic [PTR_W-1:0]       grant_d;
  logic [PTR_W-1:0]       cand_d;
  logic [PTR_W-1:0]       p_next_d;

  // Unpack the address bus and pack the per-consumer data registers.
  for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_slices
    assign addr_arr[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
    assign consumer_read_data[i*DATA_BITS +: DATA_BITS] = data_q[i];
  end

  // Rotating-priority search: first requester at or above p, wrapping around.
  always_comb begin
    any_req_d = 1'b0;
    grant_d   = p_q;
    cand_d    = p_q;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      cand_d = PTR_W'((int'(p_q) + k) % NUM_CONSUMERS);
      if (!any_req_d && consumer_read_valid[cand_d]) begin
        any_req_d = 1'b1;
        grant_d   = cand_d;
      end
    end
  end

  // Pointer moves just past the consumer that was served last.
  always_comb begin
    p_next_d = (g_q == PTR_W'(NUM_CONSUMERS - 1)) ? '0 : g_q + 1'b1;
  end

  // Request/response FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      g_q         <= '0;
      p_q         <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      ready_q     <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            g_q         <= grant_d;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= addr_arr[grant_d];
            state_q     <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // The read completes even if the fetcher gave up meanwhile.
          if (mem_read_ready) begin
            data_q[g_q]  <= mem_read_data;
            ready_q[g_q] <= 1'b1;
            mem_valid_q  <= 1'b0;
            state_q      <= RELAY;
          end
        end
        RELAY: begin
          if (!consumer_read_valid[g_q]) begin
            ready_q <= '0;
            p_q     <= p_next_d;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign consumer_read_ready = ready_q;
  assign mem_read_valid      = mem_valid_q;
  assign mem_read_address    = mem_addr_q;

endmodule

// File: tb/tb_program_mem_responder.sv
// tb/tb_program_mem_responder.sv - self-checking bench for program_mem_responder
module tb_program_mem_responder;
  localparam int AB = 8;
  localparam int DB = 16;
  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NC-1:0]   consumer_read_valid = '0;
  logic [NC*AB-1:0] consumer_read_address = '0;
  logic [NC-1:0]   consumer_read_ready;
  logic [NC*DB-1:0] consumer_read_data;
  logic            mem_read_valid;
  logic [AB-1:0]   mem_read_address;
  logic            mem_read_ready = 1'b0;
  logic [DB-1:0]   mem_read_data = '0;

  int checks = 0;
  int errors = 0;

  // Memory model
  logic [DB-1:0] mem_arr [256];
  bit            mem_busy = 0;
  int            mem_cnt = 0;
  logic [AB-1:0] mem_cap = '0;
  int            fixed_lat = 0;
  bit            spur_pending = 0;
  bit            mem_noise = 0;
  logic [AB-1:0] addr_log [$];

  // Fetcher agents
  bit            agent_on = 0;
  int            rem [NC];
  int            nxt [NC];
  logic [AB-1:0] addr_tab [NC][8];
  int            comp_id [$];
  logic [DB-1:0] comp_data [$];

  // Reference: index the next search starts from
  int model_p = 0;

  always #5 clk = ~clk;

  program_mem_responder #(
    .ADDR_BITS(AB),
    .DATA_BITS(DB),
    .NUM_CONSUMERS(NC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .consumer_read_valid(consumer_read_valid),
    .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready),
    .consumer_read_data(consumer_read_data),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data)
  );

  task automatic mem_step();
    mem_read_ready = 1'b0;
    mem_read_data  = DB'($urandom);
    if (!reset) begin
      mem_busy = 0;
      if (mem_noise) mem_read_ready = 1'($urandom);
      return;
    end
    if (spur_pending) begin
      mem_read_ready = 1'b1;
      spur_pending = 0;
      return;
    end
    if (!mem_busy && mem_read_valid) begin
      mem_busy = 1;
      mem_cap  = mem_read_address;
      addr_log.push_back(mem_cap);
      mem_cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_read_ready = 1'b1;
        mem_read_data  = mem_arr[mem_cap];
        mem_busy = 0;
      end
    end
  endtask

  task automatic agent_step();
    for (int i = 0; i < NC; i++) begin
      if (consumer_read_valid[i] && consumer_read_ready[i]) begin
        comp_id.push_back(i);
        comp_data.push_back(consumer_read_data[i*DB +: DB]);
        consumer_read_valid[i] = 1'b0;
      end else if (!consumer_read_valid[i] && !consumer_read_ready[i] && rem[i] > 0) begin
        consumer_read_address[i*AB +: AB] = addr_tab[i][nxt[i]];
        nxt[i]++;
        rem[i]--;
        consumer_read_valid[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_step();
    if (agent_on) agent_step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    consumer_read_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    model_p = 0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_noise = 1;
    repeat (5) begin
      consumer_read_valid   = NC'($urandom);
      consumer_read_address = (NC*AB)'($urandom);
      tick();
      checks++; if (consumer_read_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 0", consumer_read_ready); end
      checks++; if (consumer_read_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", consumer_read_data); end
      checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b expected 0", mem_read_valid); end
      checks++; if (mem_read_address !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_read_address); end
    end
    consumer_read_valid = '0;
    mem_noise = 0;
    reset = 1'b1;
    model_p = 0;
    repeat (5) begin
      tick();
      checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL idle_mem_valid: got %b expected 0", mem_read_valid); end
      checks++; if (consumer_read_ready !== '0) begin errors++; $display("FAIL idle_ready: got %b expected 0", consumer_read_ready); end
    end
  endtask

  task automatic test_single_fetch();
    int n;
    fixed_lat = 3;
    mem_arr[8'h1A] = 16'hBEEF;
    consumer_read_address[2*AB +: AB] = 8'h1A;
    consumer_read_valid[2] = 1'b1;
    n = 1;
    tick();
    checks++; if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h1A) begin errors++; $display("FAIL single_req: got valid=%b addr=%h expected 1/1a", mem_read_valid, mem_read_address); end
    while (consumer_read_ready[2] !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL single_latency: got %0d edges expected 4", n); end
    checks++; if (consumer_read_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", consumer_read_ready); end
    checks++; if (consumer_read_data[2*DB +: DB] !== 16'hBEEF) begin errors++; $display("FAIL single_data: got %h expected beef", consumer_read_data[2*DB +: DB]); end
    checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL single_mem_drop: got %b expected 0", mem_read_valid); end
    tick();
    checks++; if (consumer_read_ready !== 4'b0100) begin errors++; $display("FAIL single_ready_hold: got %b expected 0100", consumer_read_ready); end
    consumer_read_valid[2] = 1'b0;
    tick();
    checks++; if (consumer_read_ready !== '0) begin errors++; $display("FAIL single_ready_fall: got %b expected 0", consumer_read_ready); end
    checks++; if (consumer_read_data[2*DB +: DB] !== 16'hBEEF) begin errors++; $display("FAIL single_data_hold: got %h expected beef", consumer_read_data[2*DB +: DB]); end
    tick();
    checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", mem_read_valid); end
    model_p = 3;
    fixed_lat = 0;
  endtask

  task automatic run_traffic(input int n0, input int n1, input int n2, input int n3, input string tag);
    int cnt [NC];
    int left [NC];
    int exp_id [$];
    logic [AB-1:0] exp_addr [$];
    int total;
    int p;
    int budget;
    cnt = '{n0, n1, n2, n3};
    total = n0 + n1 + n2 + n3;
    for (int i = 0; i < NC; i++) begin
      for (int k = 0; k < cnt[i]; k++) addr_tab[i][k] = AB'($urandom);
      nxt[i] = 0;
      rem[i] = cnt[i];
      left[i] = cnt[i];
    end
    // Every consumer that still owes requests is waiting at each grant.
    p = model_p;
    for (int t = 0; t < total; t++) begin
      for (int s = 0; s < NC; s++) begin
        int j;
        j = (p + s) % NC;
        if (left[j] > 0) begin
          exp_id.push_back(j);
          exp_addr.push_back(addr_tab[j][cnt[j] - left[j]]);
          left[j]--;
          p = (j + 1) % NC;
          break;
        end
      end
    end
    model_p = p;
    addr_log.delete();
    comp_id.delete();
    comp_data.delete();
    agent_on = 1;
    budget = 0;
    while (comp_id.size() < total && budget < 2000) begin
      tick();
      budget++;
      checks++; if ($countones(consumer_read_ready) > 1) begin errors++; $display("FAIL %s_onehot: got %b expected at most one bit", tag, consumer_read_ready); end
    end
    checks++; if (comp_id.size() != total) begin errors++; $display("FAIL %s_timeout: got %0d completions expected %0d", tag, comp_id.size(), total); end
    repeat (3) tick();
    agent_on = 0;
    checks++; if (addr_log.size() != total) begin errors++; $display("FAIL %s_reqcount: got %0d expected %0d", tag, addr_log.size(), total); end
    for (int t = 0; t < total; t++) begin
      if (t < addr_log.size()) begin
        checks++; if (addr_log[t] !== exp_addr[t]) begin errors++; $display("FAIL %s_addr[%0d]: got %h expected %h", tag, t, addr_log[t], exp_addr[t]); end
      end
      if (t < comp_id.size()) begin
        checks++; if (comp_id[t] != exp_id[t]) begin errors++; $display("FAIL %s_order[%0d]: got %0d expected %0d", tag, t, comp_id[t], exp_id[t]); end
        checks++; if (comp_data[t] !== mem_arr[exp_addr[t]]) begin errors++; $display("FAIL %s_data[%0d]: got %h expected %h", tag, t, comp_data[t], mem_arr[exp_addr[t]]); end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    run_traffic(2, 1, 0, 1, "rr");
  endtask

  task automatic test_wrap();
    run_traffic(0, 0, 1, 0, "wrap_setup");
    run_traffic(1, 0, 0, 1, "wrap");
  endtask

  task automatic test_early_drop();
    logic [AB-1:0] a;
    logic [NC*DB-1:0] saved;
    int n;
    fixed_lat = 3;
    a = AB'($urandom);
    consumer_read_address[1*AB +: AB] = a;
    consumer_read_valid[1] = 1'b1;
    tick();
    checks++; if (mem_read_valid !== 1'b1 || mem_read_address !== a) begin errors++; $display("FAIL drop_req: got valid=%b addr=%h expected 1/%h", mem_read_valid, mem_read_address, a); end
    consumer_read_valid[1] = 1'b0;
    n = 1;
    while (consumer_read_ready[1] !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (consumer_read_ready !== 4'b0010) begin errors++; $display("FAIL drop_ready: got %b expected 0010", consumer_read_ready); end
    checks++; if (consumer_read_data[1*DB +: DB] !== mem_arr[a]) begin errors++; $display("FAIL drop_data: got %h expected %h", consumer_read_data[1*DB +: DB], mem_arr[a]); end
    tick();
    checks++; if (consumer_read_ready !== '0) begin errors++; $display("FAIL drop_pulse: got %b expected 0", consumer_read_ready); end
    checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL drop_idle: got %b expected 0", mem_read_valid); end
    saved = consumer_read_data;
    spur_pending = 1;
    tick();
    tick();
    checks++; if (consumer_read_ready !== '0) begin errors++; $display("FAIL spur_ready: got %b expected 0", consumer_read_ready); end
    checks++; if (mem_read_valid !== 1'b0) begin errors++; $display("FAIL spur_mem_valid: got %b expected 0", mem_read_valid); end
    checks++; if (consumer_read_data !== saved) begin errors++; $display("FAIL spur_data: got %h expected %h", consumer_read_data, saved); end
    model_p = 2;
    fixed_lat = 0;
  endtask

  task automatic test_mid_reset();
    logic [AB-1:0] a1;
    logic [AB-1:0] a3;
    fixed_lat = 4;
    a3 = AB'($urandom);
    consumer_read_address[3*AB +: AB] = a3;
    consumer_read_valid[3] = 1'b1;
    tick();
    tick();
    checks++; if (mem_read_valid !== 1'b1) begin errors++; $display("FAIL mid_wait: got %b expected 1", mem_read_valid); end
    reset = 1'b0;
    #2;
    checks++; if (mem_read_valid !== 1'b0 || mem_read_address !== '0) begin errors++; $display("FAIL mid_mem_clear: got valid=%b addr=%h expected 0/0", mem_read_valid, mem_read_address); end
    checks++; if (consumer_read_ready !== '0 || consumer_read_data !== '0) begin errors++; $display("FAIL mid_cons_clear: got ready=%b data=%h expected 0/0", consumer_read_ready, consumer_read_data); end
    consumer_read_valid = '0;
    tick();
    reset = 1'b1;
    model_p = 0;
    spur_pending = 1;
    tick();
    tick();
    checks++; if (consumer_read_ready !== '0 || mem_read_valid !== 1'b0) begin errors++; $display("FAIL mid_late_resp: got ready=%b valid=%b expected 0/0", consumer_read_ready, mem_read_valid); end
    a1 = AB'($urandom);
    consumer_read_address[1*AB +: AB] = a1;
    consumer_read_valid[1] = 1'b1;
    consumer_read_valid[3] = 1'b1;
    tick();
    checks++; if (mem_read_valid !== 1'b1 || mem_read_address !== a1) begin errors++; $display("FAIL mid_regrant: got valid=%b addr=%h expected 1/%h", mem_read_valid, mem_read_address, a1); end
    consumer_read_valid = '0;
    fixed_lat = 0;
    do_reset();
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      run_traffic(int'($urandom_range(1, 6)), int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), "rand");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = DB'($urandom);
    #2;
    reset = 1'b0;
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_wrap();
    test_early_drop();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
